// File: rtl/dp_cmd_fifo_pkg.sv
`default_nettype none
//==============================================================================
// Module      : dp_cmd_fifo_pkg
// Description : Shared types and constants for the decoder command queue.
//               Defines the command packet width, the presented-packet
//               structure {valid, packet} and the 2-bit opcode encodings
//               carried in the packet MSBs.
// Revision    : 1.0 - initial release
//==============================================================================
`ifndef PACKET_SIZE
`define PACKET_SIZE 10
`endif

package dp_cmd_fifo_pkg;

    localparam int C_PKT_W = `PACKET_SIZE;

    // Packet as presented to the decoder: valid flag above the payload.
    typedef struct packed {
        logic               valid;
        logic [C_PKT_W-1:0] packet;
    } com_packet;

    // Opcode occupies the two MSBs of the payload.
    localparam logic [1:0] OP_TASK   = 2'b00;
    localparam logic [1:0] OP_REPLAY = 2'b01;
    localparam logic [1:0] OP_NUMFV  = 2'b10;
    localparam logic [1:0] OP_WBOUND = 2'b11;

    function automatic logic [1:0] pkt_opcode(input logic [C_PKT_W-1:0] pkt);
        return pkt[C_PKT_W-1 -: 2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dp_cmd_fifo_mem.sv
`default_nettype none
//==============================================================================
// Module      : cmd_fifo_mem
// Description : DEPTH x WIDTH register array with one synchronous write port
//               and one asynchronous read port.
// Ports       : clk        - clock
//               i_wr_en    - write enable
//               i_wr_addr  - write address
//               i_wr_data  - write data
//               i_rd_addr  - read address
//               o_rd_data  - read data (combinational from i_rd_addr)
// Revision    : 1.0 - initial release
//==============================================================================
module cmd_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage is not reset; pointer logic guarantees no stale entry is read.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/dp_cmd_fifo.sv
`default_nettype none
//==============================================================================
// Module      : dp_cmd_fifo
// Description : Command queue feeding the decoder. Buffers loader packets in
//               a circular buffer and presents them one per cycle through a
//               registered {valid, packet} output, honouring fifo_stall so
//               every packet is delivered exactly once. Reports occupancy and
//               a peak-occupancy watermark.
// Ports       : clk          - clock
//               reset        - synchronous active-high reset
//               wr_valid     - loader offers wr_packet
//               wr_packet    - command packet from loader
//               wr_ready     - not full; write accepted on wr_valid&&wr_ready
//               fifo_stall   - decoder stall, same-cycle
//               flush        - drop stored and presented packets
//               com2DPpacket - registered {valid, packet} to decoder
//               empty        - storage empty (output register excluded)
//               occupancy    - stored entry count 0..DEPTH
//               peak_occ     - max occupancy since reset/flush
// Revision    : 1.0 - initial release
//==============================================================================
`ifndef PACKET_SIZE
`define PACKET_SIZE 10
`endif

module dp_cmd_fifo
    import dp_cmd_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PKT_W = `PACKET_SIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [PKT_W-1:0]         wr_packet,
    output logic                     wr_ready,
    input  logic                     fifo_stall,
    input  logic                     flush,
    output com_packet                com2DPpacket,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [$clog2(DEPTH):0]   peak_occ
);

    localparam int C_AW = $clog2(DEPTH);

    // Pointers carry an extra wrap bit to distinguish full from empty.
    logic [C_AW:0]      r_wr_ptr;
    logic [C_AW:0]      r_rd_ptr;
    logic [C_AW:0]      r_peak;
    com_packet          r_out;

    logic               w_full;
    logic               w_empty;
    logic               w_wr;
    logic               w_pop;
    logic [C_AW:0]      w_wr_ptr_nxt;
    logic [C_AW:0]      w_rd_ptr_nxt;
    logic [C_AW:0]      w_occ_nxt;
    logic [PKT_W-1:0]   w_rd_data;

    assign w_full  = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                     (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Full comes straight from the registered pointers, so a pop in the
    // full cycle frees space only for the following cycle's write.
    assign w_wr  = wr_valid && !w_full && !flush;
    assign w_pop = !fifo_stall && !w_empty && !flush;

    assign w_wr_ptr_nxt = r_wr_ptr + {{C_AW{1'b0}}, w_wr};
    assign w_rd_ptr_nxt = r_rd_ptr + {{C_AW{1'b0}}, w_pop};
    assign w_occ_nxt    = w_wr_ptr_nxt - w_rd_ptr_nxt;

    cmd_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PKT_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wr_ptr[C_AW-1:0]),
        .i_wr_data (wr_packet),
        .i_rd_addr (r_rd_ptr[C_AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_peak   <= '0;
            r_out    <= '0;
        end else if (flush) begin
            // Payload field holds; only valid is dropped.
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_peak       <= '0;
            r_out.valid  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            if (w_occ_nxt > r_peak) begin
                r_peak <= w_occ_nxt;
            end
            if (w_pop) begin
                r_out.valid  <= 1'b1;
                r_out.packet <= w_rd_data;
            end else begin
                r_out.valid  <= 1'b0;
            end
        end
    end

    assign wr_ready     = !w_full;
    assign empty        = w_empty;
    assign occupancy    = r_wr_ptr - r_rd_ptr;
    assign peak_occ     = r_peak;
    assign com2DPpacket = r_out;

endmodule

`default_nettype wire

// File: tb/tb_dp_cmd_fifo.sv
`default_nettype none
//==============================================================================
// Module      : tb_dp_cmd_fifo
// Description : Directed self-checking bench for dp_cmd_fifo: ordering,
//               stall handling, full backpressure, pointer wrap, flush and
//               mid-operation reset.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_dp_cmd_fifo;
    import dp_cmd_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int PKT_W = C_PKT_W;

    logic             clk;
    logic             reset;
    logic             wr_valid;
    logic [PKT_W-1:0] wr_packet;
    logic             wr_ready;
    logic             fifo_stall;
    logic             flush;
    com_packet        com2DPpacket;
    logic             empty;
    logic [4:0]       occupancy;
    logic [4:0]       peak_occ;

    int n_assert = 0;
    int n_fail   = 0;

    dp_cmd_fifo #(
        .DEPTH (DEPTH),
        .PKT_W (PKT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_packet    (wr_packet),
        .wr_ready     (wr_ready),
        .fifo_stall   (fifo_stall),
        .flush        (flush),
        .com2DPpacket (com2DPpacket),
        .empty        (empty),
        .occupancy    (occupancy),
        .peak_occ     (peak_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [PKT_W-1:0] p);
        chk({tag, ".valid"}, {31'd0, com2DPpacket.valid}, {31'd0, v});
        if (v) chk({tag, ".pkt"}, {22'd0, com2DPpacket.packet}, {22'd0, p});
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_packet = '0; fifo_stall = 1'b0; flush = 1'b0;
        tick(); tick();
        chk("rst.valid",  {31'd0, com2DPpacket.valid}, 32'd0);
        chk("rst.pkt",    {22'd0, com2DPpacket.packet}, 32'd0);
        chk("rst.empty",  {31'd0, empty}, 32'd1);
        chk("rst.wrrdy",  {31'd0, wr_ready}, 32'd1);
        chk("rst.occ",    {27'd0, occupancy}, 32'd0);
        chk("rst.peak",   {27'd0, peak_occ}, 32'd0);
        reset = 1'b0;

        // T1: four packets, no stall; no write-to-read bypass.
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_packet = PKT_W'(10'h100 + i);
            tick();
            if (i == 0) chk_out("t1.first", 1'b0, '0);
            else        chk_out("t1.stream", 1'b1, PKT_W'(10'h100 + i - 1));
        end
        wr_valid = 1'b0;
        tick();
        chk_out("t1.last", 1'b1, 10'h103);
        tick();
        chk_out("t1.drain", 1'b0, '0);
        chk("t1.hold",  {22'd0, com2DPpacket.packet}, 32'h103);
        chk("t1.empty", {31'd0, empty}, 32'd1);
        chk("t1.peak",  {27'd0, peak_occ}, 32'd1);

        // T2: stall raised while P1 is visible, held 5 cycles.
        fifo_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_packet = PKT_W'(10'h110 + i);
            tick();
        end
        wr_valid = 1'b0;
        chk("t2.occ", {27'd0, occupancy}, 32'd4);
        fifo_stall = 1'b0;
        tick(); chk_out("t2.p0", 1'b1, 10'h110);
        tick(); chk_out("t2.p1", 1'b1, 10'h111);
        fifo_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); chk_out("t2.stalled", 1'b0, '0);
        end
        fifo_stall = 1'b0;
        tick(); chk_out("t2.p2", 1'b1, 10'h112);
        tick(); chk_out("t2.p3", 1'b1, 10'h113);
        tick(); chk_out("t2.done", 1'b0, '0);
        chk("t2.peak", {27'd0, peak_occ}, 32'd4);

        // T3: fill to DEPTH under stall, 17th write held until a pop.
        fifo_stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_packet = PKT_W'(10'h120 + i);
            tick();
        end
        chk("t3.wrrdy", {31'd0, wr_ready}, 32'd0);
        chk("t3.occ",   {27'd0, occupancy}, 32'd16);
        chk("t3.peak",  {27'd0, peak_occ}, 32'd16);
        wr_packet = 10'h1FF;
        tick();
        chk("t3.held.occ", {27'd0, occupancy}, 32'd16);
        fifo_stall = 1'b0;
        for (int k = 0; k < 17; k++) begin
            tick();
            if (k == 0) begin
                chk("t3.pop.occ",   {27'd0, occupancy}, 32'd15);
                chk("t3.pop.wrrdy", {31'd0, wr_ready}, 32'd1);
            end
            if (k == 1) wr_valid = 1'b0;
            chk_out("t3.stream", 1'b1, (k < 16) ? PKT_W'(10'h120 + k) : 10'h1FF);
        end
        tick();
        chk_out("t3.done", 1'b0, '0);
        chk("t3.empty", {31'd0, empty}, 32'd1);
        chk("t3.peaksat", {27'd0, peak_occ}, 32'd16);

        // T4: 20 packets streamed through, pointers wrap.
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1; wr_packet = PKT_W'(10'h140 + i);
            tick();
            if (i > 0) chk_out("t4.stream", 1'b1, PKT_W'(10'h140 + i - 1));
        end
        wr_valid = 1'b0;
        tick(); chk_out("t4.last", 1'b1, 10'h153);
        tick(); chk_out("t4.done", 1'b0, '0);
        chk("t4.occ",   {27'd0, occupancy}, 32'd0);
        chk("t4.empty", {31'd0, empty}, 32'd1);

        // T5: flush at occupancy 6 with valid output and a concurrent write.
        fifo_stall = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1; wr_packet = PKT_W'(10'h160 + i);
            tick();
        end
        wr_valid = 1'b0; fifo_stall = 1'b0;
        tick();
        chk_out("t5.pre", 1'b1, 10'h160);
        chk("t5.pre.occ", {27'd0, occupancy}, 32'd6);
        flush = 1'b1; wr_valid = 1'b1; wr_packet = 10'h3EE;
        tick();
        flush = 1'b0; wr_valid = 1'b0;
        chk_out("t5.valid", 1'b0, '0);
        chk("t5.occ",   {27'd0, occupancy}, 32'd0);
        chk("t5.peak",  {27'd0, peak_occ}, 32'd0);
        chk("t5.wrrdy", {31'd0, wr_ready}, 32'd1);
        chk("t5.empty", {31'd0, empty}, 32'd1);
        tick(); chk_out("t5.nodeliver", 1'b0, '0);
        wr_valid = 1'b1; wr_packet = 10'h170;
        tick(); wr_valid = 1'b0;
        tick(); chk_out("t5.after", 1'b1, 10'h170);

        // T6: reset with occupancy 9 and valid output.
        fifo_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_packet = PKT_W'(10'h180 + i);
            tick();
        end
        wr_valid = 1'b0; fifo_stall = 1'b0;
        tick();
        chk_out("t6.pre", 1'b1, 10'h180);
        chk("t6.pre.occ", {27'd0, occupancy}, 32'd9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6.valid", {31'd0, com2DPpacket.valid}, 32'd0);
        chk("t6.pkt",   {22'd0, com2DPpacket.packet}, 32'd0);
        chk("t6.occ",   {27'd0, occupancy}, 32'd0);
        chk("t6.peak",  {27'd0, peak_occ}, 32'd0);
        chk("t6.empty", {31'd0, empty}, 32'd1);
        chk("t6.wrrdy", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b1; wr_packet = 10'h2AA;
        tick(); wr_valid = 1'b0;
        chk_out("t6.nobypass", 1'b0, '0);
        tick(); chk_out("t6.first", 1'b1, 10'h2AA);
        tick(); chk_out("t6.done", 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
